gpio_event_unit: RTL and testbench

Parametrised successor to the CPU's button FIFO/switch/LED I/O path. Synchronises and debounces N push-buttons, converts debounced rising edges into timestamp-free event entries in a configurable-depth FIFO with sticky overflow, and exposes buttons, switches and LEDs to the memory controller through a small word-addressed register port with one-cycle read latency. It sits beside the UART and instruction counter under the memory controller's I/O decode.

---
 rtl/gpio_event_pkg.sv | 16 +
 rtl/gpio_debounce.sv | 47 ++++
 rtl/gpio_event_unit.sv | 122 ++++++++++++
 tb/tb_gpio_event_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_event_pkg.sv
// gpio_event_pkg: register map and bit positions shared by the GPIO event unit and its bench
package gpio_event_pkg;
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_EVENT    = 3'd1;
    localparam logic [2:0] REG_BUTTONS  = 3'd2;
    localparam logic [2:0] REG_SWITCHES = 3'd3;
    localparam logic [2:0] REG_LEDS     = 3'd4;
    localparam logic [2:0] REG_CONTROL  = 3'd5;
    localparam int ST_EMPTY_BIT     = 0;
    localparam int ST_FULL_BIT      = 1;
    localparam int ST_OVF_BIT       = 2;
    localparam int ST_COUNT_LSB     = 16;
    localparam int EV_VALID_BIT     = 31;
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one button channel -- 2-flop synchroniser, stability counter, debounced level and rise pulse
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, sync_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // accept the new level once it has differed for DEBOUNCE_CYCLES consecutive cycles
    always_comb begin
        accept  = (sync_q != level_q) && (cnt_q == CNT_LAST);
        level_d = accept ? sync_q : level_q;
        cnt_d   = (sync_q == level_q || accept) ? '0 : cnt_q + 1'b1;
        rise_d  = accept & sync_q;
    end

    // synchroniser, counter and debounced state; rise is registered so the push lands one cycle after acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= raw_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
endmodule

// File: rtl/gpio_event_unit.sv
// gpio_event_unit: debounced button events into a FIFO plus button/switch/LED register port
module gpio_event_unit
    import gpio_event_pkg::*;
#(
    parameter int N_BUTTONS       = 3,
    parameter int N_SWITCHES      = 2,
    parameter int N_LEDS          = 6,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_BUTTONS-1:0]  buttons_raw,
    input  logic [N_SWITCHES-1:0] switches,
    output logic [N_LEDS-1:0]     leds,
    input  logic [2:0]            reg_addr,
    input  logic                  reg_rd_en,
    input  logic                  reg_wr_en,
    input  logic [31:0]           reg_wr_data,
    output logic [31:0]           reg_rd_data,
    output logic                  event_pending
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [N_BUTTONS-1:0]  level, rise;
    logic [N_SWITCHES-1:0] sw_meta_q, sw_sync_q;
    logic [N_BUTTONS-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [N_LEDS-1:0]     led_q, led_d;
    logic [31:0]           rd_data_q, rd_data_d, rd_word;
    logic                  empty, full, push, pop, push_ok, drop, flush, clr_ovf, wr_ctrl;
    logic                  unused_wr_data;

    genvar i;
    generate
        for (i = 0; i < N_BUTTONS; i++) begin : g_btn
            gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk     (clk),
                .rst     (rst),
                .raw_i   (buttons_raw[i]),
                .level_o (level[i]),
                .rise_o  (rise[i])
            );
        end
    endgenerate

    // FIFO control: flush beats push, a pop frees room for a same-cycle push into a full FIFO
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(FIFO_DEPTH));
        wr_ctrl  = reg_wr_en && (reg_addr == REG_CONTROL);
        flush    = wr_ctrl && reg_wr_data[CTRL_FLUSH_BIT];
        clr_ovf  = wr_ctrl && reg_wr_data[CTRL_CLR_OVF_BIT];
        push     = |rise;
        pop      = reg_rd_en && (reg_addr == REG_EVENT) && !empty;
        push_ok  = push && (!full || pop) && !flush;
        drop     = push && full && !pop && !flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push_ok);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d  = flush ? '0 : count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = clr_ovf ? 1'b0 : (ovf_q | drop);
        led_d    = (reg_wr_en && reg_addr == REG_LEDS) ? reg_wr_data[N_LEDS-1:0] : led_q;
    end

    // register read mux; captured into rd_data_q only on a read strobe
    always_comb begin
        rd_word = '0;
        case (reg_addr)
            REG_STATUS: begin
                rd_word[ST_EMPTY_BIT]         = empty;
                rd_word[ST_FULL_BIT]          = full;
                rd_word[ST_OVF_BIT]           = ovf_q;
                rd_word[ST_COUNT_LSB +: CW]   = count_q;
            end
            REG_EVENT: begin
                rd_word[EV_VALID_BIT]         = !empty;
                rd_word[N_BUTTONS-1:0]        = empty ? '0 : mem_q[rd_ptr_q];
            end
            REG_BUTTONS:  rd_word[N_BUTTONS-1:0]  = level;
            REG_SWITCHES: rd_word[N_SWITCHES-1:0] = sw_sync_q;
            REG_LEDS:     rd_word[N_LEDS-1:0]     = led_q;
            default:      rd_word = '0;
        endcase
        rd_data_d = reg_rd_en ? rd_word : rd_data_q;
    end

    // control and status state
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            led_q     <= '0;
            rd_data_q <= '0;
        end else begin
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            led_q     <= led_d;
            rd_data_q <= rd_data_d;
        end
    end

    // event storage needs no reset; count gates every read of it
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= rise;
    end

    assign unused_wr_data = ^reg_wr_data;
    assign leds           = led_q;
    assign reg_rd_data    = rd_data_q;
    assign event_pending  = !empty;
endmodule

// File: tb/tb_gpio_event_unit.sv
// tb_gpio_event_unit: scenario tasks with a scoreboard of expected EVENT words
module tb_gpio_event_unit;
    import gpio_event_pkg::*;
    localparam int NB = 3, NS = 2, NL = 6, DC = 4, FD = 4;

    logic          clk = 1'b0, rst = 1'b1;
    logic [NB-1:0] buttons_raw = '0;
    logic [NS-1:0] switches = '0;
    logic [NL-1:0] leds;
    logic [2:0]    reg_addr = '0;
    logic          reg_rd_en = 1'b0, reg_wr_en = 1'b0;
    logic [31:0]   reg_wr_data = '0, reg_rd_data;
    logic          event_pending;
    int            tests = 0, fails = 0;
    logic [31:0]   sb [$];
    logic [31:0]   d, exp_v;

    gpio_event_unit #(
        .N_BUTTONS(NB), .N_SWITCHES(NS), .N_LEDS(NL),
        .DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .buttons_raw(buttons_raw), .switches(switches), .leds(leds),
        .reg_addr(reg_addr), .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en),
        .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .event_pending(event_pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] v);
        reg_addr = a; reg_rd_en = 1'b1;
        step();
        reg_rd_en = 1'b0;
        v = reg_rd_data;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] v);
        reg_addr = a; reg_wr_data = v; reg_wr_en = 1'b1;
        step();
        reg_wr_en = 1'b0;
    endtask

    task automatic press(input logic [NB-1:0] m);
        buttons_raw = m;
        repeat (8) step();
        buttons_raw = '0;
        repeat (12) step();
        if (sb.size() < FD) sb.push_back(32'h8000_0000 | 32'(m));
    endtask

    task automatic test_reset();
        tests++; if (leds !== '0) begin fails++; $display("FAIL reset_leds got %h want 0", leds); end
        tests++; if (reg_rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data got %h want 0", reg_rd_data); end
        tests++; if (event_pending !== 1'b0) begin fails++; $display("FAIL reset_pending got %b want 0", event_pending); end
        reg_read(REG_STATUS, d);
        tests++; if (d !== 32'h1) begin fails++; $display("FAIL reset_status got %h want 00000001", d); end
    endtask

    task automatic test_debounce();
        buttons_raw = 3'b001;
        repeat (3) step();
        buttons_raw = '0;
        repeat (12) step();
        tests++; if (event_pending !== 1'b0) begin fails++; $display("FAIL short_press_pending got %b want 0", event_pending); end
        reg_read(REG_STATUS, d);
        tests++; if (d !== 32'h1) begin fails++; $display("FAIL short_press_status got %h want 00000001", d); end
        buttons_raw = 3'b001;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) begin
                tests++; if (event_pending !== 1'b0) begin fails++; $display("FAIL latency_early got %b want 0", event_pending); end
            end
            if (i == 7) begin
                tests++; if (event_pending !== 1'b1) begin fails++; $display("FAIL latency_push got %b want 1", event_pending); end
            end
        end
        sb.push_back(32'h8000_0001);
        reg_read(REG_BUTTONS, d);
        tests++; if (d !== 32'h1) begin fails++; $display("FAIL buttons_level got %h want 00000001", d); end
        buttons_raw = '0;
        repeat (12) step();
        reg_read(REG_EVENT, d);
        exp_v = sb.size() ? sb.pop_front() : 32'h0;
        tests++; if (d !== exp_v) begin fails++; $display("FAIL debounce_event got %h want %h", d, exp_v); end
        reg_read(REG_STATUS, d);
        tests++; if (d !== 32'h1) begin fails++; $display("FAIL debounce_status got %h want 00000001", d); end
    endtask

    task automatic test_simultaneous();
        press(3'b101);
        reg_read(REG_STATUS, d);
        tests++; if (d !== 32'h0001_0000) begin fails++; $display("FAIL simul_status got %h want 00010000", d); end
        reg_read(REG_EVENT, d);
        exp_v = sb.size() ? sb.pop_front() : 32'h0;
        tests++; if (d !== exp_v || d !== 32'h8000_0005) begin fails++; $display("FAIL simul_event got %h want %h", d, exp_v); end
    endtask

    task automatic test_overflow();
        press(3'b001); press(3'b010); press(3'b100); press(3'b011); press(3'b110);
        reg_read(REG_STATUS, d);
        tests++; if (d !== 32'h0004_0006) begin fails++; $display("FAIL ovf_status got %h want 00040006", d); end
        for (int k = 0; k < 5; k++) begin
            reg_read(REG_EVENT, d);
            exp_v = sb.size() ? sb.pop_front() : 32'h0;
            tests++; if (d !== exp_v) begin fails++; $display("FAIL ovf_read%0d got %h want %h", k, d, exp_v); end
        end
        reg_write(REG_CONTROL, 32'h2);
        reg_read(REG_STATUS, d);
        tests++; if (d !== 32'h1) begin fails++; $display("FAIL ovf_clear got %h want 00000001", d); end
    endtask

    task automatic test_back_to_back();
        press(3'b001); press(3'b010); press(3'b100); press(3'b101);
        buttons_raw = 3'b011;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) begin reg_addr = REG_EVENT; reg_rd_en = 1'b1; end
            if (i == 7) begin
                reg_rd_en = 1'b0;
                exp_v = sb.size() ? sb.pop_front() : 32'h0;
                tests++; if (reg_rd_data !== exp_v) begin fails++; $display("FAIL b2b_pop got %h want %h", reg_rd_data, exp_v); end
                sb.push_back(32'h8000_0003);
            end
        end
        buttons_raw = '0;
        repeat (12) step();
        reg_read(REG_STATUS, d);
        tests++; if (d !== 32'h0004_0002) begin fails++; $display("FAIL b2b_status got %h want 00040002", d); end
        for (int k = 0; k < 5; k++) begin
            reg_read(REG_EVENT, d);
            exp_v = sb.size() ? sb.pop_front() : 32'h0;
            tests++; if (d !== exp_v) begin fails++; $display("FAIL b2b_drain%0d got %h want %h", k, d, exp_v); end
        end
    endtask

    task automatic test_regs();
        reg_write(REG_LEDS, 32'h2A);
        tests++; if (leds !== 6'b101010) begin fails++; $display("FAIL leds_write got %b want 101010", leds); end
        reg_read(REG_LEDS, d);
        tests++; if (d !== 32'h2A) begin fails++; $display("FAIL leds_read got %h want 0000002a", d); end
        reg_addr = REG_LEDS; reg_wr_data = 32'h15; reg_wr_en = 1'b1; reg_rd_en = 1'b1;
        step();
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        tests++; if (reg_rd_data !== 32'h2A) begin fails++; $display("FAIL rdwr_old got %h want 0000002a", reg_rd_data); end
        tests++; if (leds !== 6'h15) begin fails++; $display("FAIL rdwr_leds got %h want 15", leds); end
        switches = 2'b10;
        repeat (3) step();
        reg_read(REG_SWITCHES, d);
        tests++; if (d !== 32'h2) begin fails++; $display("FAIL switches got %h want 00000002", d); end
        reg_read(REG_CONTROL, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL control_read got %h want 0", d); end
        reg_write(3'd6, 32'hFFFF_FFFF);
        reg_read(3'd6, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL reg6_read got %h want 0", d); end
        press(3'b001); press(3'b010); press(3'b100); press(3'b011); press(3'b110);
        reg_write(REG_CONTROL, 32'h3);
        sb.delete();
        reg_read(REG_STATUS, d);
        tests++; if (d !== 32'h1) begin fails++; $display("FAIL control_flush got %h want 00000001", d); end
        tests++; if (event_pending !== 1'b0) begin fails++; $display("FAIL flush_pending got %b want 0", event_pending); end
    endtask

    task automatic test_reset_mid();
        press(3'b001); press(3'b010);
        reg_write(REG_LEDS, 32'h3F);
        reg_addr = REG_STATUS; reg_rd_en = 1'b1; rst = 1'b1;
        step();
        reg_rd_en = 1'b0; rst = 1'b0;
        sb.delete();
        tests++; if (leds !== '0) begin fails++; $display("FAIL rst_leds got %h want 0", leds); end
        tests++; if (event_pending !== 1'b0) begin fails++; $display("FAIL rst_pending got %b want 0", event_pending); end
        tests++; if (reg_rd_data !== 32'h0) begin fails++; $display("FAIL rst_rd_data got %h want 0", reg_rd_data); end
        reg_read(REG_STATUS, d);
        tests++; if (d !== 32'h1) begin fails++; $display("FAIL rst_status got %h want 00000001", d); end
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        test_reset();
        test_debounce();
        test_simultaneous();
        test_overflow();
        test_back_to_back();
        test_regs();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
